// File: rtl/instruction_block_loader_if.sv
// Imem write handshake plus AXI4 read-only (AR/R) channels of the instruction block loader.
// The loader sits on the master modport; DRAM and imem models use the slave modport.
interface instruction_block_loader_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 42,
  parameter int unsigned DATA_WIDTH     = 64
);
  logic                      imem_wr_start;
  logic                      imem_wr_done;
  logic                      imem_wr_data_valid;
  logic [DATA_WIDTH-1:0]     imem_wr_data;

  logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]                m_axi_arlen;
  logic [2:0]                m_axi_arsize;
  logic [1:0]                m_axi_arburst;
  logic                      m_axi_arvalid;
  logic                      m_axi_arready;

  logic [DATA_WIDTH-1:0]     m_axi_rdata;
  logic [1:0]                m_axi_rresp;
  logic                      m_axi_rlast;
  logic                      m_axi_rvalid;
  logic                      m_axi_rready;

  modport master (
    input  imem_wr_start,
    output imem_wr_done, imem_wr_data_valid, imem_wr_data,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output imem_wr_start,
    input  imem_wr_done, imem_wr_data_valid, imem_wr_data,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/instruction_block_loader.sv
// AXI4 read master that fetches one instruction block per imem_wr_start request from
// contiguous DRAM and streams it into the double-buffered instruction memory.
module instruction_block_loader #(
  parameter int unsigned NUM_INST_IN     = 2,
  parameter int unsigned INST_DATA_WIDTH = 32,
  parameter int unsigned INST_ADDR_WIDTH = 10,
  parameter int unsigned AXI_ADDR_WIDTH  = 42,
  parameter int unsigned AXI_MAX_BURST   = 16,
  localparam int unsigned BLK_W = INST_ADDR_WIDTH - $clog2(NUM_INST_IN) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [15:0]               cfg_num_blocks,
  input  logic [BLK_W-1:0]          cfg_block_beats,
  output logic                      load_done,
  output logic                      load_err,
  instruction_block_loader_if.master bus
);

  localparam int unsigned DATA_W         = NUM_INST_IN * INST_DATA_WIDTH;
  localparam int unsigned BYTES_PER_BEAT = DATA_W / 8;
  localparam int unsigned BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
  localparam int unsigned CAPACITY       = 1 << (BLK_W - 1);
  localparam int unsigned BURST_W        = $clog2(AXI_MAX_BURST) + 1;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWaitReq = 3'd1;
  localparam logic [2:0] StAddr    = 3'd2;
  localparam logic [2:0] StData    = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]               blocks_left_q, blocks_left_d;
  logic [BLK_W-1:0]          block_beats_q, block_beats_d;
  logic [BLK_W-1:0]          beats_left_q, beats_left_d;
  logic [BURST_W-1:0]        burst_len_q, burst_len_d;
  logic [BURST_W-1:0]        burst_left_q, burst_left_d;
  logic [7:0]                arlen_q, arlen_d;
  logic                      pending_q, pending_d;
  logic                      wr_valid_q, wr_valid_d;
  logic [DATA_W-1:0]         wr_data_q, wr_data_d;
  logic                      done_q, done_d;
  logic                      load_done_q, load_done_d;
  logic                      load_err_q, load_err_d;

  logic [BLK_W-1:0]          beats_src;
  logic [31:0]               to_4k;
  logic [31:0]               len_calc;
  logic                      last_beat;

  // Next burst length: limited by beats left, max burst and the next 4KB boundary.
  always_comb begin
    beats_src = (state_q == StWaitReq) ? block_beats_q : beats_left_q;
    to_4k     = (32'd4096 - 32'(addr_q[11:0])) >> BEAT_SHIFT;
    len_calc  = 32'(beats_src);
    if (len_calc > AXI_MAX_BURST) len_calc = AXI_MAX_BURST;
    if (len_calc > to_4k)         len_calc = to_4k;
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    blocks_left_d = blocks_left_q;
    block_beats_d = block_beats_q;
    beats_left_d  = beats_left_q;
    burst_len_d   = burst_len_q;
    burst_left_d  = burst_left_q;
    arlen_d       = arlen_q;
    pending_d     = pending_q;
    wr_valid_d    = 1'b0;
    wr_data_d     = wr_data_q;
    done_d        = 1'b0;
    load_done_d   = 1'b0;
    load_err_d    = load_err_q;
    last_beat     = (burst_left_q == BURST_W'(1));

    case (state_q)
      StIdle: begin
        if (start) begin
          addr_d        = cfg_base_addr;
          blocks_left_d = cfg_num_blocks;
          block_beats_d = (32'(cfg_block_beats) > CAPACITY) ? BLK_W'(CAPACITY) : cfg_block_beats;
          load_err_d    = 1'b0;
          pending_d     = 1'b0;
          if (cfg_num_blocks == 16'd0) load_done_d = 1'b1;
          else                         state_d     = StWaitReq;
        end
      end
      StWaitReq: begin
        if (pending_q) begin
          pending_d    = 1'b0;
          beats_left_d = block_beats_q;
          if (block_beats_q == '0) begin
            state_d = StDone;
          end else begin
            state_d     = StAddr;
            arlen_d     = 8'(len_calc - 32'd1);
            burst_len_d = BURST_W'(len_calc);
          end
        end
      end
      StAddr: begin
        if (bus.m_axi_arready) begin
          state_d      = StData;
          addr_d       = addr_q + AXI_ADDR_WIDTH'(32'(burst_len_q) << BEAT_SHIFT);
          beats_left_d = beats_left_q - BLK_W'(burst_len_q);
          burst_left_d = burst_len_q;
        end
      end
      StData: begin
        if (bus.m_axi_rvalid) begin
          wr_valid_d   = 1'b1;
          wr_data_d    = bus.m_axi_rdata;
          burst_left_d = burst_left_q - BURST_W'(1);
          if (bus.m_axi_rresp != 2'b00) load_err_d = 1'b1;
          // A mismatched rlast still closes the burst so the FSM cannot stall.
          if (bus.m_axi_rlast != last_beat) load_err_d = 1'b1;
          if (bus.m_axi_rlast || last_beat) begin
            if (beats_left_q != '0) begin
              state_d     = StAddr;
              arlen_d     = 8'(len_calc - 32'd1);
              burst_len_d = BURST_W'(len_calc);
            end else begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        done_d        = 1'b1;
        blocks_left_d = blocks_left_q - 16'd1;
        if (blocks_left_q == 16'd1) begin
          state_d     = StIdle;
          load_done_d = 1'b1;
        end else begin
          state_d = StWaitReq;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new request outranks the clear of the one just consumed.
    if (bus.imem_wr_start && (state_q != StIdle)) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      blocks_left_q <= '0;
      block_beats_q <= '0;
      beats_left_q  <= '0;
      burst_len_q   <= '0;
      burst_left_q  <= '0;
      arlen_q       <= '0;
      pending_q     <= 1'b0;
      wr_valid_q    <= 1'b0;
      wr_data_q     <= '0;
      done_q        <= 1'b0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      blocks_left_q <= blocks_left_d;
      block_beats_q <= block_beats_d;
      beats_left_q  <= beats_left_d;
      burst_len_q   <= burst_len_d;
      burst_left_q  <= burst_left_d;
      arlen_q       <= arlen_d;
      pending_q     <= pending_d;
      wr_valid_q    <= wr_valid_d;
      wr_data_q     <= wr_data_d;
      done_q        <= done_d;
      load_done_q   <= load_done_d;
      load_err_q    <= load_err_d;
    end
  end

  assign bus.m_axi_arvalid      = (state_q == StAddr);
  assign bus.m_axi_araddr       = bus.m_axi_arvalid ? addr_q : '0;
  assign bus.m_axi_arlen        = bus.m_axi_arvalid ? arlen_q : 8'd0;
  assign bus.m_axi_arsize       = bus.m_axi_arvalid ? 3'(BEAT_SHIFT) : 3'd0;
  assign bus.m_axi_arburst      = bus.m_axi_arvalid ? 2'b01 : 2'b00;
  assign bus.m_axi_rready       = (state_q == StData);
  assign bus.imem_wr_data_valid = wr_valid_q;
  assign bus.imem_wr_data       = wr_data_q;
  assign bus.imem_wr_done       = done_q;
  assign load_done              = load_done_q;
  assign load_err               = load_err_q;

endmodule

// File: tb/tb_instruction_block_loader.sv
// Scoreboard bench: tests queue expected AR requests and imem writes; a monitor pops and
// compares them as the loader presents them, while a DRAM model answers the AXI reads.
module tb_instruction_block_loader;
  localparam int unsigned AW    = 42;
  localparam int unsigned DW    = 64;
  localparam int unsigned BLK_W = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [AW-1:0]  cfg_base_addr;
  logic [15:0]    cfg_num_blocks;
  logic [BLK_W-1:0] cfg_block_beats;
  logic           load_done;
  logic           load_err;

  instruction_block_loader_if #(.AXI_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instruction_block_loader #(
    .NUM_INST_IN(2), .INST_DATA_WIDTH(32), .INST_ADDR_WIDTH(10),
    .AXI_ADDR_WIDTH(AW), .AXI_MAX_BURST(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_base_addr(cfg_base_addr),
    .cfg_num_blocks(cfg_num_blocks), .cfg_block_beats(cfg_block_beats),
    .load_done(load_done), .load_err(load_err), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_t;
  typedef struct { bit is_done; logic [DW-1:0] data; } wr_t;

  ar_t exp_ar[$];
  wr_t exp_wr[$];
  ar_t bq[$];

  int    total = 0;
  int    bad = 0;
  int    ar_delay = 0;
  int    err_beat = -1;
  int    beat_no = 0;
  int    r_idx = 0;
  int    ar_cnt = 0;
  bit    gap_en = 0;
  bit    par = 0;
  bit    r_hs = 0;
  bit    prev_hs = 0;
  bit    valid_since = 0;
  bit    ar_hold = 0;
  longint cyc = 0;
  longint last_valid_cyc = 0;
  logic [AW-1:0] hold_addr;
  logic [7:0]    hold_len;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {~a[31:0], a[31:0] ^ 32'h5A5A_0F0F};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_burst(input logic [AW-1:0] addr, input int len);
    exp_ar.push_back('{addr: addr, len: 8'(len - 1)});
    for (int i = 0; i < len; i++) exp_wr.push_back('{is_done: 1'b0, data: pat(addr + AW'(i * 8))});
  endtask

  task automatic push_done();
    exp_wr.push_back('{is_done: 1'b1, data: '0});
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, 128'({load_done, load_err, bus.imem_wr_done, bus.imem_wr_data_valid,
                      bus.imem_wr_data, bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arsize,
                      bus.m_axi_arburst, bus.m_axi_arvalid, bus.m_axi_rready}), 128'(0));
  endtask

  task automatic do_start(input logic [AW-1:0] base, input int blocks, input int beats);
    cfg_base_addr   = base;
    cfg_num_blocks  = 16'(blocks);
    cfg_block_beats = BLK_W'(beats);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_wr_start();
    bus.imem_wr_start = 1'b1;
    @(posedge clk); #1;
    bus.imem_wr_start = 1'b0;
  endtask

  task automatic wait_wr_done(input string name, input int bound);
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.imem_wr_done) begin seen = 1; break; end
    end
    check(name, 128'(seen), 128'(1));
    @(posedge clk); #1;
  endtask

  task automatic wait_load_done(input string name, input int bound);
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (load_done) begin seen = 1; break; end
    end
    check(name, 128'(seen), 128'(1));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_ar.size() == 0 && exp_wr.size() == 0) break;
      @(posedge clk); #1;
    end
    check(name, 128'(exp_ar.size() + exp_wr.size()), 128'(0));
  endtask

  // DRAM model: arready after ar_delay cycles, one burst at a time, optional rvalid gaps.
  initial begin
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rdata   = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        bq.delete();
        r_idx = 0;
        ar_cnt = 0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rresp   = 2'b00;
        continue;
      end
      bus.m_axi_arready = 1'b0;
      if (bus.m_axi_arvalid) begin
        if (ar_cnt >= ar_delay) begin bus.m_axi_arready = 1'b1; ar_cnt = 0; end
        else ar_cnt++;
      end
      if (r_hs && bq.size() > 0) begin
        beat_no++;
        r_idx++;
        if (r_idx > int'(bq[0].len)) begin void'(bq.pop_front()); r_idx = 0; end
      end
      bus.m_axi_rvalid = 1'b0;
      bus.m_axi_rlast  = 1'b0;
      bus.m_axi_rresp  = 2'b00;
      if (bq.size() > 0 && !(gap_en && par)) begin
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = pat(bq[0].addr + AW'(r_idx * 8));
        bus.m_axi_rlast  = (r_idx == int'(bq[0].len));
        bus.m_axi_rresp  = (beat_no == err_beat) ? 2'b10 : 2'b00;
      end
      par = !par;
    end
  end

  // Monitor: AR requests, R-to-write latency and imem write stream against the scoreboard.
  initial begin
    ar_t e;
    wr_t w;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        r_hs = 0; prev_hs = 0; ar_hold = 0; valid_since = 0;
        continue;
      end
      if (bus.m_axi_arvalid) begin
        if (ar_hold)
          check("ar_stable", 128'({bus.m_axi_araddr, bus.m_axi_arlen}), 128'({hold_addr, hold_len}));
        else begin
          ar_hold = 1; hold_addr = bus.m_axi_araddr; hold_len = bus.m_axi_arlen;
        end
        if (bus.m_axi_arready) begin
          ar_hold = 0;
          if (exp_ar.size() == 0) begin
            total++; bad++;
            $display("FAIL ar_unexpected got addr=%0h len=%0d exp=none",
                     bus.m_axi_araddr, bus.m_axi_arlen);
          end else begin
            e = exp_ar.pop_front();
            check("ar_addr", 128'(bus.m_axi_araddr), 128'(e.addr));
            check("ar_len", 128'(bus.m_axi_arlen), 128'(e.len));
            check("ar_size_burst", 128'({bus.m_axi_arsize, bus.m_axi_arburst}), 128'({3'd3, 2'b01}));
          end
          bq.push_back('{addr: bus.m_axi_araddr, len: bus.m_axi_arlen});
        end
      end
      if (prev_hs || bus.imem_wr_data_valid)
        check("wr_valid_timing", 128'(bus.imem_wr_data_valid), 128'(prev_hs));
      prev_hs = bus.m_axi_rvalid && bus.m_axi_rready;
      r_hs = prev_hs;
      if (bus.imem_wr_data_valid || bus.imem_wr_done)
        check("done_apart_from_valid", 128'(bus.imem_wr_data_valid && bus.imem_wr_done), 128'(0));
      if (bus.imem_wr_data_valid || bus.imem_wr_done) begin
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected got valid=%0b done=%0b data=%0h exp=none",
                   bus.imem_wr_data_valid, bus.imem_wr_done, bus.imem_wr_data);
        end else begin
          w = exp_wr.pop_front();
          if (bus.imem_wr_data_valid) begin
            check("wr_kind_data", 128'(w.is_done), 128'(0));
            check("wr_data", 128'(bus.imem_wr_data), 128'(w.data));
            valid_since = 1; last_valid_cyc = cyc;
          end else begin
            check("wr_kind_done", 128'(w.is_done), 128'(1));
            if (valid_since) check("done_gap", 128'(cyc - last_valid_cyc), 128'(1));
            valid_since = 0;
          end
        end
      end
    end
  end

  initial begin
    bit arv_seen;
    int nvalid;
    start = 1'b0;
    bus.imem_wr_start = 1'b0;
    cfg_base_addr = '0;
    cfg_num_blocks = '0;
    cfg_block_beats = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2 check_outputs_zero("reset_outputs");
    repeat (3) @(posedge clk);
    @(negedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;

    // One block of 8 beats.
    push_burst(42'h1000, 8); push_done();
    do_start(42'h1000, 1, 8);
    pulse_wr_start();
    wait_load_done("t1_load_done", 300);
    drain("t1_drain");
    check("t1_load_err", 128'(load_err), 128'(0));

    // 40 beats split at the max burst size.
    push_burst(42'h2000, 16); push_burst(42'h2080, 16); push_burst(42'h2100, 8); push_done();
    do_start(42'h2000, 1, 40);
    pulse_wr_start();
    wait_load_done("t2_load_done", 500);
    drain("t2_drain");

    // 4KB boundary split.
    push_burst(42'hFF8, 1); push_burst(42'h1000, 3); push_done();
    do_start(42'hFF8, 1, 4);
    pulse_wr_start();
    wait_load_done("t3_load_done", 300);
    drain("t3_drain");

    // Address wrap at the top of the address space.
    push_burst(42'h3FF_FFFF_FFF0, 2); push_burst(42'h0, 2); push_done();
    do_start(42'h3FF_FFFF_FFF0, 1, 4);
    pulse_wr_start();
    wait_load_done("t9_load_done", 300);
    drain("t9_drain");

    // Three blocks with a delayed second request.
    push_burst(42'h3000, 8); push_done();
    push_burst(42'h3040, 8); push_done();
    push_burst(42'h3080, 8); push_done();
    do_start(42'h3000, 3, 8);
    pulse_wr_start();
    wait_wr_done("t4_blk0_done", 300);
    arv_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      arv_seen |= bus.m_axi_arvalid;
    end
    check("t4_holdoff_no_ar", 128'(arv_seen), 128'(0));
    @(posedge clk); #1;
    pulse_wr_start();
    wait_wr_done("t4_blk1_done", 300);
    pulse_wr_start();
    wait_load_done("t4_load_done", 300);
    drain("t4_drain");

    // Slow arready, rvalid gaps, SLVERR on beat 3.
    ar_delay = 10; gap_en = 1; beat_no = 0; err_beat = 3;
    push_burst(42'h4000, 8); push_done();
    do_start(42'h4000, 1, 8);
    pulse_wr_start();
    wait_load_done("t5_load_done", 500);
    drain("t5_drain");
    check("t5_load_err", 128'(load_err), 128'(1));
    ar_delay = 0; gap_en = 0; err_beat = -1;

    // Zero blocks: load_done the cycle after start, error flag cleared.
    do_start(42'h0, 0, 8);
    @(negedge clk);
    check("t6_load_done_next", 128'(load_done), 128'(1));
    check("t6_load_err_clear", 128'(load_err), 128'(0));
    @(posedge clk); #1;

    // Zero-beat block: done without any AXI traffic.
    push_done();
    do_start(42'h8000, 1, 0);
    pulse_wr_start();
    wait_load_done("t7_load_done", 100);
    drain("t7_drain");

    // Oversized block clamps to 512 beats.
    for (int i = 0; i < 32; i++) push_burst(42'h10000 + AW'(i * 128), 16);
    push_done();
    do_start(42'h10000, 1, 600);
    pulse_wr_start();
    wait_load_done("t8_load_done", 2000);
    drain("t8_drain");

    // Reset in the middle of a burst.
    push_burst(42'h5000, 16); push_burst(42'h5080, 16); push_burst(42'h5100, 8); push_done();
    do_start(42'h5000, 1, 40);
    pulse_wr_start();
    nvalid = 0;
    for (int i = 0; i < 200 && nvalid < 5; i++) begin
      @(negedge clk);
      if (bus.imem_wr_data_valid) nvalid++;
    end
    check("t10_mid_burst_reached", 128'(nvalid), 128'(5));
    #1 reset = 1'b1;
    #1 check_outputs_zero("t10_async_reset_outputs");
    exp_ar.delete();
    exp_wr.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;

    push_burst(42'h6000, 8); push_done();
    do_start(42'h6000, 1, 8);
    pulse_wr_start();
    wait_load_done("t11_load_done", 300);
    drain("t11_drain");
    check("t11_load_err", 128'(load_err), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
